// File: rtl/mtsp_srcop_pkg.sv
// Shared types and the per-lane sign modifier for the MTSP source-operate pipe.
package mtsp_srcop_pkg;

  typedef enum logic [1:0] {
    SRCOP_PASS = 2'd0,
    SRCOP_NEG  = 2'd1,
    SRCOP_ABS  = 2'd2,
    SRCOP_NABS = 2'd3
  } srcop_e;

  // Widest lane the modifier handles; callers zero-extend narrower lanes.
  localparam int unsigned SRCOP_MAXDW = 64;

  function automatic logic [SRCOP_MAXDW-1:0] srcop_apply(
    input srcop_e                  op,
    input logic                    mask,
    input logic [SRCOP_MAXDW-1:0]  lane,
    input logic [5:0]              sbit
  );
    logic [SRCOP_MAXDW-1:0] r;
    r = lane;
    case (op)
      SRCOP_NEG:  r[sbit] = ~lane[sbit];
      SRCOP_ABS:  r[sbit] = 1'b0;
      SRCOP_NABS: r[sbit] = 1'b1;
      default:    r = lane;
    endcase
    if (!mask) r = '0;
    return r;
  endfunction

endpackage

// File: rtl/mtsp_srcop_stage.sv
// Generic valid/ready register slice; payload loads only when the slot is refilled.
module mtsp_srcop_stage #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o
);

  logic         v_q, v_d;
  logic         load;
  logic [W-1:0] data_q;

  always_comb begin
    in_ready_o = !v_q || out_ready_i;
    load       = in_valid_i && in_ready_o;
    v_d        = load || (v_q && !out_ready_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q    <= 1'b0;
      data_q <= '0;
    end else begin
      v_q <= v_d;
      if (load) data_q <= in_data_i;
    end
  end

  assign out_valid_o = v_q;
  assign out_data_o  = data_q;

endmodule

// File: rtl/mtsp_src_operate_pipe.sv
// Two-stage source-operand modifier: S1 registers the swizzled lanes, S2 the sign-modified lanes.
module mtsp_src_operate_pipe
  import mtsp_srcop_pkg::*;
#(
  parameter  int unsigned LANES = 4,
  parameter  int unsigned DW    = 32,
  parameter  int unsigned TAGW  = 4,
  localparam int unsigned SW    = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                CLK,
  input  logic                nRST,
  input  logic                IN_VALID,
  output logic                IN_READY,
  input  logic [1:0]          IN_OP,
  input  logic [LANES*SW-1:0] IN_SWZ,
  input  logic [LANES-1:0]    IN_MASK,
  input  logic [LANES*DW-1:0] IN_DATA,
  input  logic [TAGW-1:0]     IN_TAG,
  output logic                OUT_VALID,
  input  logic                OUT_READY,
  output logic [LANES*DW-1:0] OUT_DATA,
  output logic [LANES-1:0]    OUT_MASK,
  output logic [TAGW-1:0]     OUT_TAG,
  output logic                BUSY
);

  localparam int unsigned W1 = 2 + LANES + TAGW + LANES*DW;
  localparam int unsigned W2 = LANES + TAGW + LANES*DW;

  logic [LANES*DW-1:0] swz_data;
  logic [W1-1:0]       s1_data;
  logic                s1_v;
  logic                s2_ready;
  logic [1:0]          s1_op;
  logic [LANES-1:0]    s1_mask;
  logic [TAGW-1:0]     s1_tag;
  logic [LANES*DW-1:0] s1_lanes;
  logic [LANES*DW-1:0] mod_data;
  logic [W2-1:0]       s2_data;
  logic                s2_v;

  // Out-of-range selectors (non-power-of-2 LANES) and the single-lane case fall back to lane 0.
  always_comb begin
    swz_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      int unsigned src;
      src = 32'(IN_SWZ[i*SW +: SW]);
      if (LANES == 1 || src >= LANES) src = 0;
      swz_data[i*DW +: DW] = IN_DATA[src*DW +: DW];
    end
  end

  mtsp_srcop_stage #(.W(W1)) u_s1 (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .in_valid_i  (IN_VALID),
    .in_ready_o  (IN_READY),
    .in_data_i   ({IN_OP, IN_MASK, IN_TAG, swz_data}),
    .out_valid_o (s1_v),
    .out_ready_i (s2_ready),
    .out_data_o  (s1_data)
  );

  assign {s1_op, s1_mask, s1_tag, s1_lanes} = s1_data;

  always_comb begin
    mod_data = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      logic [SRCOP_MAXDW-1:0] ext;
      logic [SRCOP_MAXDW-1:0] res;
      ext          = '0;
      ext[DW-1:0]  = s1_lanes[i*DW +: DW];
      res          = srcop_apply(srcop_e'(s1_op), s1_mask[i], ext, 6'(DW-1));
      mod_data[i*DW +: DW] = res[DW-1:0];
    end
  end

  mtsp_srcop_stage #(.W(W2)) u_s2 (
    .clk_i       (CLK),
    .rst_ni      (nRST),
    .in_valid_i  (s1_v),
    .in_ready_o  (s2_ready),
    .in_data_i   ({s1_mask, s1_tag, mod_data}),
    .out_valid_o (s2_v),
    .out_ready_i (OUT_READY),
    .out_data_o  (s2_data)
  );

  assign {OUT_MASK, OUT_TAG, OUT_DATA} = s2_data;
  assign OUT_VALID = s2_v;
  assign BUSY      = s1_v | s2_v;

endmodule

// File: tb/tb_mtsp_src_operate_pipe.sv
// Self-checking bench for mtsp_src_operate_pipe: vector table, scoreboard, stall/reset sequences, parameter sweep.
module tb_mtsp_src_operate_pipe;

  typedef struct {
    logic [1:0]   op;
    logic [7:0]   swz;
    logic [3:0]   mask;
    logic [127:0] data;
    logic [3:0]   tag;
    logic [127:0] exp;
  } vec_t;

  typedef struct {
    logic [127:0] data;
    logic [3:0]   mask;
    logic [3:0]   tag;
  } exp_t;

  logic         clk, nrst;
  logic         in_valid, in_ready, out_valid, out_ready, busy;
  logic [1:0]   in_op;
  logic [7:0]   in_swz;
  logic [3:0]   in_mask, in_tag, out_mask, out_tag;
  logic [127:0] in_data, out_data;

  logic         sv;
  logic         p1_ir, p1_ov, p1_busy, p1_om;
  logic [0:0]   p1_swz;
  logic [15:0]  p1_data, p1_out;
  logic [3:0]   p1_otag;
  logic         p3_ir, p3_ov, p3_busy;
  logic [5:0]   p3_swz;
  logic [2:0]   p3_om;
  logic [47:0]  p3_data, p3_out;
  logic [3:0]   p3_otag;
  logic         p8_ir, p8_ov, p8_busy;
  logic [23:0]  p8_swz;
  logic [7:0]   p8_om;
  logic [127:0] p8_data, p8_out;
  logic [3:0]   p8_otag;

  int   checks = 0;
  int   failures = 0;
  int   xfers = 0;
  exp_t sb[$];
  exp_t mon_e;
  bit   hold_v;
  logic [127:0] held_data;
  logic [3:0]   held_mask, held_tag;
  vec_t tbl[8];

  mtsp_src_operate_pipe #(.LANES(4), .DW(32), .TAGW(4)) dut (
    .CLK(clk), .nRST(nrst), .IN_VALID(in_valid), .IN_READY(in_ready), .IN_OP(in_op),
    .IN_SWZ(in_swz), .IN_MASK(in_mask), .IN_DATA(in_data), .IN_TAG(in_tag),
    .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
    .OUT_MASK(out_mask), .OUT_TAG(out_tag), .BUSY(busy)
  );

  mtsp_src_operate_pipe #(.LANES(1), .DW(16), .TAGW(4)) u_p1 (
    .CLK(clk), .nRST(nrst), .IN_VALID(sv), .IN_READY(p1_ir), .IN_OP(2'd1),
    .IN_SWZ(p1_swz), .IN_MASK(1'b1), .IN_DATA(p1_data), .IN_TAG(4'hA),
    .OUT_VALID(p1_ov), .OUT_READY(1'b1), .OUT_DATA(p1_out),
    .OUT_MASK(p1_om), .OUT_TAG(p1_otag), .BUSY(p1_busy)
  );

  mtsp_src_operate_pipe #(.LANES(3), .DW(16), .TAGW(4)) u_p3 (
    .CLK(clk), .nRST(nrst), .IN_VALID(sv), .IN_READY(p3_ir), .IN_OP(2'd2),
    .IN_SWZ(p3_swz), .IN_MASK(3'b111), .IN_DATA(p3_data), .IN_TAG(4'hB),
    .OUT_VALID(p3_ov), .OUT_READY(1'b1), .OUT_DATA(p3_out),
    .OUT_MASK(p3_om), .OUT_TAG(p3_otag), .BUSY(p3_busy)
  );

  mtsp_src_operate_pipe #(.LANES(8), .DW(16), .TAGW(4)) u_p8 (
    .CLK(clk), .nRST(nrst), .IN_VALID(sv), .IN_READY(p8_ir), .IN_OP(2'd3),
    .IN_SWZ(p8_swz), .IN_MASK(8'hF0), .IN_DATA(p8_data), .IN_TAG(4'hC),
    .OUT_VALID(p8_ov), .OUT_READY(1'b1), .OUT_DATA(p8_out),
    .OUT_MASK(p8_om), .OUT_TAG(p8_otag), .BUSY(p8_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] model(input logic [1:0] op, input logic [7:0] swz,
                                         input logic [3:0] mask, input logic [127:0] d);
    logic [127:0] r;
    logic [31:0]  w;
    logic [1:0]   s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = swz[2*i +: 2];
      w = d[32*s +: 32];
      case (op)
        2'd1: w = w ^ 32'h8000_0000;
        2'd2: w = w & 32'h7FFF_FFFF;
        2'd3: w = w | 32'h8000_0000;
        default: ;
      endcase
      if (mask[i]) r[32*i +: 32] = w;
    end
    return r;
  endfunction

  function automatic vec_t mkrand(input logic [3:0] tag);
    vec_t v;
    v.op   = 2'($urandom_range(0, 3));
    v.swz  = 8'($urandom);
    v.mask = 4'($urandom);
    v.data = {$urandom, $urandom, $urandom, $urandom};
    v.tag  = tag;
    v.exp  = model(v.op, v.swz, v.mask, v.data);
    return v;
  endfunction

  task automatic drive(input vec_t v);
    in_op   = v.op;
    in_swz  = v.swz;
    in_mask = v.mask;
    in_data = v.data;
    in_tag  = v.tag;
  endtask

  task automatic send(input vec_t v);
    int n;
    bit acc;
    drive(v);
    in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 100) begin
      @(negedge clk);
      if (in_ready) begin
        acc = 1'b1;
        sb.push_back('{v.exp, v.mask, v.tag});
      end
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=no_accept required=accept tag=%h", v.tag);
    end
  endtask

  task automatic lat_probe(input vec_t v, input string name);
    int lat;
    drive(v);
    in_valid = 1'b1;
    @(negedge clk);
    chk({name, "_accept"}, in_ready, 1'b1);
    if (in_ready) sb.push_back('{v.exp, v.mask, v.tag});
    lat = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
    end while (!out_valid && lat < 10);
    chk(name, lat, 2);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk(name, sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!nrst) begin
      hold_v = 1'b0;
    end else begin
      if (hold_v) begin
        checks++;
        if (!out_valid || out_data !== held_data || out_mask !== held_mask || out_tag !== held_tag) begin
          failures++;
          $display("FAIL hold actual=%0b/%h/%h/%h required=1/%h/%h/%h",
                   out_valid, out_data, out_mask, out_tag, held_data, held_mask, held_tag);
        end
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_unexpected actual=tag_%h required=no_output", out_tag);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_data", out_data, mon_e.data);
          chk("sb_mask_tag", {out_mask, out_tag}, {mon_e.mask, mon_e.tag});
        end
        xfers++;
      end
      hold_v    = out_valid && !out_ready;
      held_data = out_data;
      held_mask = out_mask;
      held_tag  = out_tag;
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_n, x0;
    bit rdy_ok;
    vec_t v;

    tbl[0] = '{2'd0, 8'hE4, 4'hF, 128'h40400000_C0000000_3F800000_00000000, 4'd1,
               128'h40400000_C0000000_3F800000_00000000};
    tbl[1] = '{2'd1, 8'hE4, 4'hF, 128'h40400000_C0000000_3F800000_00000000, 4'd2,
               128'hC0400000_40000000_BF800000_80000000};
    tbl[2] = '{2'd2, 8'hE4, 4'hF, 128'h40400000_C0000000_3F800000_00000000, 4'd3,
               128'h40400000_40000000_3F800000_00000000};
    tbl[3] = '{2'd3, 8'hE4, 4'hF, 128'h40400000_C0000000_3F800000_00000000, 4'd4,
               128'hC0400000_C0000000_BF800000_80000000};
    tbl[4] = '{2'd0, 8'hE4, 4'h5, 128'h40400000_C0000000_3F800000_00000000, 4'd5,
               128'h00000000_C0000000_00000000_00000000};
    tbl[5] = '{2'd0, 8'h00, 4'hF, 128'h11111111_22222222_33333333_3F800000, 4'd6,
               128'h3F800000_3F800000_3F800000_3F800000};
    tbl[6] = '{2'd2, 8'h1B, 4'hF, 128'h40400000_C0000000_3F800000_00000000, 4'd7,
               128'h00000000_3F800000_40000000_40400000};
    tbl[7] = '{2'd1, 8'h00, 4'h1, 128'h00000000_00000000_00000000_7FC00000, 4'd8,
               128'h00000000_00000000_00000000_FFC00000};

    clk = 1'b0; nrst = 1'b0; sv = 1'b0;
    in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_swz = '0; in_mask = '0; in_data = '0; in_tag = '0;
    p1_swz = 1'b1; p1_data = 16'h3C00;
    p3_swz = 6'h1B; p3_data = 48'h4000_C200_3C00;
    p8_swz = 24'h053977; p8_data = 128'h7007_6006_5005_4004_3003_2002_1001_0000;

    #12;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_mask_tag", {out_mask, out_tag}, '0);
    @(posedge clk); #1;
    nrst = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1'b1);

    lat_probe(tbl[0], "latency_identity");
    for (int i = 1; i < 8; i++) send(tbl[i]);
    wait_drain("drain_table");

    // Stall with an empty pipe: exactly two operands fit before IN_READY drops.
    out_ready = 1'b0;
    v = mkrand(4'd9);
    drive(v);
    in_valid = 1'b1;
    acc_n = 0;
    repeat (5) begin
      @(negedge clk);
      if (in_ready) begin
        acc_n++;
        sb.push_back('{model(in_op, in_swz, in_mask, in_data), in_mask, in_tag});
      end
      @(posedge clk); #1;
      in_tag = in_tag + 4'd1;
    end
    chk("stall_accepts", acc_n, 2);
    chk("stall_in_ready", in_ready, 1'b0);
    chk("stall_busy_valid", {busy, out_valid}, 2'b11);
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_drain("drain_stall");

    x0 = xfers;
    fork
      for (int t = 0; t < 6; t++) send(mkrand(4'(t)));
      begin
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain("drain_backpressure");
    chk("backpressure_count", xfers - x0, 6);

    x0 = xfers;
    rdy_ok = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      v = mkrand(4'(i));
      drive(v);
      @(negedge clk);
      if (!in_ready) rdy_ok = 1'b0;
      else sb.push_back('{v.exp, v.mask, v.tag});
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("thru_in_ready", rdy_ok, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("thru_count", xfers - x0, 100);
    wait_drain("drain_thru");

    out_ready = 1'b0;
    send(mkrand(4'hD));
    send(mkrand(4'hE));
    @(posedge clk); #3;
    nrst = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 1'b0);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_out_data", out_data, '0);
    sb.delete();
    @(posedge clk);
    @(posedge clk); #1;
    nrst = 1'b1;
    out_ready = 1'b1;
    lat_probe(tbl[1], "latency_after_reset");
    wait_drain("drain_reset");

    sv = 1'b1;
    @(posedge clk); #1;
    sv = 1'b0;
    @(posedge clk); #1;
    chk("p1_valid_tag", {p1_ov, p1_om, p1_otag}, {1'b1, 1'b1, 4'hA});
    chk("p1_neg_bit15", p1_out, 16'hBC00);
    chk("p3_valid_tag", {p3_ov, p3_om, p3_otag}, {1'b1, 3'b111, 4'hB});
    chk("p3_abs_oor_swz", p3_out, 48'h4200_4000_3C00);
    chk("p8_valid_tag", {p8_ov, p8_om, p8_otag}, {1'b1, 8'hF0, 4'hC});
    chk("p8_nabs_rev_swz", p8_out, 128'h8000_9001_A002_B003_0000_0000_0000_0000);
    @(posedge clk); #1;
    chk("sweep_idle", {p1_busy, p3_busy, p8_busy}, 3'b000);

    chk("sb_empty_end", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mtsp_src_operate_pipe.md
Name: mtsp_src_operate_pipe

Overview:
- Parametrised, pipelined source-operand modifier for the MTSP core. Generalises the fixed 4-lane combinational source-operate stage.
- Per-lane swizzle, per-lane enable mask and a float sign modifier (pass/neg/abs/nabs) over LANES lanes of DW bits.
- Two-stage valid/ready pipeline with a tag sideband; sits between operand fetch and the ALU issue port.

Parameters:
- LANES, 4, number of lanes (1..8).
- DW, 32, lane width in bits; the sign bit is DW-1.
- TAGW, 4, width of the opaque sideband tag carried with each operand.
- SW (localparam), max(1,$clog2(LANES)), width of one swizzle selector.

Ports:
- CLK  input  1  core clock; all state changes on the rising edge.
- nRST  input  1  asynchronous active-low reset.
- IN_VALID  input  1  upstream operand valid.
- IN_READY  output  1  block can accept an operand this cycle.
- IN_OP  input  2  modifier: 0 pass, 1 neg (invert sign), 2 abs (clear sign), 3 nabs (set sign).
- IN_SWZ  input  LANES*SW  per-lane source selector; lane i uses bits [i*SW +: SW].
- IN_MASK  input  LANES  lane enable; a disabled lane outputs all-zero.
- IN_DATA  input  LANES*DW  source lanes; lane i is bits [i*DW +: DW].
- IN_TAG  input  TAGW  sideband, passed through unchanged.
- OUT_VALID  output  1  result valid.
- OUT_READY  input  1  downstream accepts the result.
- OUT_DATA  output  LANES*DW  modified lanes.
- OUT_MASK  output  LANES  mask delayed with the data.
- OUT_TAG  output  TAGW  tag delayed with the data.
- BUSY  output  1  either stage holds a valid entry.

Behaviour:
- Reset (nRST low, asynchronous): both stage valid flags = 0. OUT_VALID=0, BUSY=0, OUT_DATA=0, OUT_MASK=0, OUT_TAG=0. IN_READY=1 combinationally once reset is released.
- Stage S1 (swizzle): on accept, registers swz_lane[i] = IN_DATA lane IN_SWZ[i], plus IN_OP, IN_MASK and IN_TAG.
- Swizzle index >= LANES (non-power-of-2 LANES) selects lane 0. With LANES=1 the selector is ignored.
- Stage S2 (modify): registers the op applied to each lane's bit DW-1. Bits DW-2:0 pass unchanged. A lane with mask=0 becomes 0.
- Modifier is a pure bit operation: no NaN/denormal special-casing (neg of NaN flips the sign).
- Latency: exactly 2 cycles from accept to OUT_VALID with no back-pressure. Throughput: 1 operand/cycle.
- Handshake rules:
  - A transfer occurs when VALID && READY on the same edge.
  - OUT_DATA, OUT_MASK and OUT_TAG hold stable while OUT_VALID && !OUT_READY.
  - OUT_VALID never drops without a transfer.
- Per-stage advance:
  - s2_load = s1_v && (!s2_v || OUT_READY).
  - s1_load = IN_VALID && IN_READY.
  - IN_READY = !s1_v || s2_load. This is combinational from OUT_READY; no combinational IN_VALID->IN_READY path.
- Valid-flag updates:
  - s1_v <= s1_load | (s1_v & !s2_load).
  - s2_v <= s2_load | (s2_v & !OUT_READY).
- Full condition: both stages valid and OUT_READY=0, so IN_READY=0. No data is dropped or overwritten.
- Simultaneous events: when full and OUT_READY=1 the pipe shifts and accepts a new input in the same cycle.
- Empty: OUT_VALID=0. OUT_DATA holds its last value and is don't-care.
- Reset mid-operation: in-flight operands are discarded. No partial output appears after reset.
- BUSY = s1_v | s2_v.
- Data registers load only on their stage load enable.

Decomposition:
- Shared package mtsp_srcop_pkg:
  - typedef enum srcop_e {SRCOP_PASS, SRCOP_NEG, SRCOP_ABS, SRCOP_NABS} (2 bits).
  - Function srcop_apply(op, mask, lane) on one lane, parametrised by DW through the sign-bit position.
- One sub-module, mtsp_srcop_stage: a generic valid/ready register slice of parametrised payload width.
  - Instantiated twice; the swizzle and modify logic sits between the instances.

Test Plan:
- Identity path: LANES=4, op=PASS, SWZ={3,2,1,0} (lane 3 first), MASK=4'hF, DATA={40400000,C0000000,3F800000,00000000}, OUT_READY=1 -> OUT_VALID 2 cycles later with identical data and tag.
- Modifiers on lane value C0000000: NEG -> 40000000; ABS -> 40000000; NABS on 3F800000 -> BF800000; mask=4'b0101 zeroes lanes 1 and 3.
- Broadcast swizzle: SWZ={0,0,0,0} with lane0=3F800000, others distinct -> all four output lanes 3F800000.
- Back-pressure: stream 6 operands with tags 0..5 while OUT_READY=0 for cycles 3..7.
  - IN_READY drops after 2 accepts; outputs hold stable while stalled.
  - After release, all tags 0..5 emerge in order with no loss or duplication.
- Full-throughput: IN_VALID=1 and OUT_READY=1 for 100 cycles -> 100 transfers in 101 cycles; IN_READY stays 1.
- Async reset with both stages full and stalled: assert nRST low mid-cycle -> OUT_VALID=0 and BUSY=0 immediately, without waiting for a clock edge. After release, the first new operand appears after exactly 2 cycles.
- Parameter sweep LANES=1,3,8 and DW=16: check sign-bit position and the out-of-range swizzle rule (LANES=3, selector 3 -> lane 0).
